// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Holds the FSM state encoding and the credited value of each coin strobe.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } vend_state_e;

  localparam logic [2:0] COIN_1_VAL = 3'd1;
  localparam logic [2:0] COIN_2_VAL = 3'd2;
  localparam logic [2:0] COIN_5_VAL = 3'd5;

  // Only meaningful when at most one strobe is high; callers reject multi-coin cycles.
  function automatic logic [2:0] coin_value(input logic c1, input logic c2, input logic c5);
    return ({3{c1}} & COIN_1_VAL) | ({3{c2}} & COIN_2_VAL) | ({3{c5}} & COIN_5_VAL);
  endfunction

endpackage

// File: rtl/vend_change_ctr.sv
// Change-return down-counter: a load of R emits R one-cycle change pulses on enabled cycles.
// The first pulse is issued on the load edge itself, so the remaining count after load is R-1.
module vend_change_ctr #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             change_pulse,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;

  // Pulses are strobes: a frozen cycle clears the pulse but keeps the remaining count.
  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    if (ena) begin
      if (load && (load_val != '0)) begin
        count_d = load_val - CNT_W'(1);
        pulse_d = 1'b1;
      end else if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign change_pulse = pulse_q;
  assign done         = (count_q == '0);

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller: coin crediting, priced purchase, and unit-by-unit change return.
// Define VEND_REFUND_EN to let cancel in CREDIT refund the full credit as change pulses.
module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE_BASE = 3,
  parameter int PRICE_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      coin_1,
  input  logic                      coin_2,
  input  logic                      coin_5,
  input  logic [$clog2(N_PROD)-1:0] sel,
  input  logic                      buy,
  input  logic                      cancel,
  output logic                      vend_valid,
  output logic [$clog2(N_PROD)-1:0] vend_id,
  output logic                      change_pulse,
  output logic                      coin_reject,
  output logic [CREDIT_W-1:0]       credit,
  output logic                      busy
);

  localparam int SEL_W = $clog2(N_PROD);
  localparam int PW    = CREDIT_W + 8;
  localparam logic [SEL_W:0]    N_PROD_L = (SEL_W + 1)'(N_PROD);
  localparam logic [CREDIT_W:0] MAX_L    = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  logic                chg_load;
  logic                chg_done;
  logic                any_coin;
  logic                multi_coin;
  logic [2:0]          coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_over;
  logic [PW-1:0]       price;
  logic                buy_ok;
  logic                cancel_ok;

  assign any_coin   = coin_1 | coin_2 | coin_5;
  assign multi_coin = (coin_1 & coin_2) | (coin_1 & coin_5) | (coin_2 & coin_5);
  assign coin_val   = coin_value(coin_1, coin_2, coin_5);
  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);
  assign coin_over  = (coin_sum > MAX_L);

  assign price  = PW'(PRICE_BASE) + PW'(sel) * PW'(PRICE_STEP);
  assign buy_ok = buy && (state_q == S_CREDIT) && ({1'b0, sel} < N_PROD_L)
                  && (PW'(credit_q) >= price);

`ifdef VEND_REFUND_EN
  assign cancel_ok = cancel && (state_q == S_CREDIT);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_ok     = 1'b0;
`endif

  // Priority is cancel > buy > coin; any coin not credited this cycle is bounced back.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_valid_d  = 1'b0;
    vend_id_d     = vend_id_q;
    coin_reject_d = 1'b0;
    chg_load      = 1'b0;
    if (ena) begin
      unique case (state_q)
        S_IDLE, S_CREDIT: begin
          if (cancel_ok) begin
            state_d       = S_CHANGE;
            chg_load      = 1'b1;
            credit_d      = credit_q - CREDIT_W'(1);
            coin_reject_d = any_coin;
          end else if (buy_ok) begin
            state_d       = S_VEND;
            credit_d      = credit_q - price[CREDIT_W-1:0];
            vend_valid_d  = 1'b1;
            vend_id_d     = sel;
            coin_reject_d = any_coin;
          end else if (any_coin) begin
            if (multi_coin || coin_over) begin
              coin_reject_d = 1'b1;
            end else begin
              credit_d = coin_sum[CREDIT_W-1:0];
              state_d  = S_CREDIT;
            end
          end
        end
        S_VEND: begin
          coin_reject_d = any_coin;
          if (credit_q != '0) begin
            state_d  = S_CHANGE;
            chg_load = 1'b1;
            credit_d = credit_q - CREDIT_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CHANGE: begin
          coin_reject_d = any_coin;
          if (chg_done) begin
            state_d = S_IDLE;
          end else begin
            credit_d = credit_q - CREDIT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      vend_valid_q  <= 1'b0;
      vend_id_q     <= '0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_valid_q  <= vend_valid_d;
      vend_id_q     <= vend_id_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  vend_change_ctr #(
    .CNT_W(CREDIT_W)
  ) u_change (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .load        (chg_load),
    .load_val    (credit_q),
    .change_pulse(change_pulse),
    .done        (chg_done)
  );

  assign vend_valid  = vend_valid_q;
  assign vend_id     = vend_id_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule
